// File: rtl/dw_fifo_responder_if.sv
// Dw data-bus bundle between the uniciclo core (master) and a memory-mapped responder (slave).
interface dw_fifo_responder_if;
    logic        DwReadEnable;
    logic        DwWriteEnable;
    logic [3:0]  DwByteEnable;
    logic [31:0] DwAddress;
    logic [31:0] DwWriteData;
    logic [31:0] DwReadData;

    modport master (
        output DwReadEnable,
        output DwWriteEnable,
        output DwByteEnable,
        output DwAddress,
        output DwWriteData,
        input  DwReadData
    );

    modport slave (
        input  DwReadEnable,
        input  DwWriteEnable,
        input  DwByteEnable,
        input  DwAddress,
        input  DwWriteData,
        output DwReadData
    );
endinterface

// File: rtl/dw_fifo_responder.sv
// Dw bus responder exposing a byte-wide TX FIFO (CPU -> consumer) and RX FIFO (producer -> CPU).
// Read data is combinational; every side effect commits on the next rising iCLK edge.
// Optional feature: define DWFIFO_LOOPBACK_EN to implement CTRL[2] (TX -> RX internal loopback).
module dw_fifo_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hFF20_0000,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    dw_fifo_responder_if.slave   dw,
    output logic                 oTxValid,
    output logic [7:0]           oTxData,
    input  logic                 iTxReady,
    input  logic                 iRxValid,
    input  logic [7:0]           iRxData,
    output logic                 oIRQ
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [CW-1:0]         cnt_t;

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    // Storage (never reset) and control state
    logic [7:0] tx_mem_q [DEPTH];
    logic [7:0] rx_mem_q [DEPTH];

    ptr_t tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    ptr_t rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    cnt_t tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    // Decoded bus and FIFO handshake terms
    logic       sel;
    logic [1:0] off;
    logic       tx_empty, tx_full, rx_empty, rx_full;
    logic [7:0] tx_head, rx_head, rx_wdata;
    logic       lb_mode, lb_move;
    logic       tx_push_req, tx_push, tx_pop, tx_ovf_set;
    logic       rx_push_req, rx_push, rx_pop, rx_ovf_set;
    logic       ctrl_wr, ovf_clr;
    logic [31:0] status_word, ctrl_word;
    logic       unused_bits;

    assign unused_bits = ^{dw.DwAddress[1:0], dw.DwByteEnable[3:1], dw.DwWriteData[31:2]};

`ifdef DWFIFO_LOOPBACK_EN
    logic lb_q, lb_d;

    assign lb_mode = lb_q;

    // Loopback enable bit of CTRL
    always_comb begin
        lb_d = lb_q;
        if (ctrl_wr) lb_d = dw.DwWriteData[2];
    end

    // Loopback enable register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) lb_q <= 1'b0;
        else         lb_q <= lb_d;
    end
`else
    assign lb_mode = 1'b0;
`endif

    // Address decode, FIFO flags, push/pop arbitration and next-state computation
    always_comb begin
        sel = (dw.DwAddress[31:4] == BASE_ADDR[31:4]);
        off = dw.DwAddress[3:2];

        tx_empty = (tx_cnt_q == '0);
        tx_full  = (tx_cnt_q == FULL_CNT);
        rx_empty = (rx_cnt_q == '0);
        rx_full  = (rx_cnt_q == FULL_CNT);
        tx_head  = tx_mem_q[tx_rd_ptr_q];
        rx_head  = rx_mem_q[rx_rd_ptr_q];

        // In loopback the external consumer sees nothing; bytes move TX -> RX internally
        oTxValid = !tx_empty && !lb_mode;
        oTxData  = tx_head;
        lb_move  = lb_mode && !tx_empty && !rx_full;

        tx_pop      = (oTxValid && iTxReady) || lb_move;
        tx_push_req = dw.DwWriteEnable && sel && (off == OFF_DATA) && dw.DwByteEnable[0];
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
        tx_push     = tx_push_req && (!tx_full || tx_pop);
        tx_ovf_set  = tx_push_req && !tx_push;

        rx_pop      = dw.DwReadEnable && sel && (off == OFF_DATA) && !rx_empty;
        rx_push_req = lb_mode ? lb_move : iRxValid;
        rx_push     = rx_push_req && (!rx_full || rx_pop);
        rx_ovf_set  = rx_push_req && !rx_push;
        rx_wdata    = lb_mode ? tx_head : iRxData;

        ctrl_wr = dw.DwWriteEnable && sel && (off == OFF_CTRL) && dw.DwByteEnable[0];
        ovf_clr = ctrl_wr && dw.DwWriteData[1];

        tx_wr_ptr_d = tx_push ? ptr_t'(tx_wr_ptr_q + 1'b1) : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop  ? ptr_t'(tx_rd_ptr_q + 1'b1) : tx_rd_ptr_q;
        rx_wr_ptr_d = rx_push ? ptr_t'(rx_wr_ptr_q + 1'b1) : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? ptr_t'(rx_rd_ptr_q + 1'b1) : rx_rd_ptr_q;

        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop)      tx_cnt_d = cnt_t'(tx_cnt_q + 1'b1);
        else if (!tx_push && tx_pop) tx_cnt_d = cnt_t'(tx_cnt_q - 1'b1);

        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop)      rx_cnt_d = cnt_t'(rx_cnt_q + 1'b1);
        else if (!rx_push && rx_pop) rx_cnt_d = cnt_t'(rx_cnt_q - 1'b1);

        // Setting an overflow flag takes priority over a simultaneous clear
        tx_ovf_d = (tx_ovf_q && !ovf_clr) || tx_ovf_set;
        rx_ovf_d = (rx_ovf_q && !ovf_clr) || rx_ovf_set;

        irq_en_d = ctrl_wr ? dw.DwWriteData[0] : irq_en_q;
        irq_d    = irq_en_q && (!rx_empty || rx_ovf_q || tx_ovf_q);
    end

    // Combinational read-back mux; zero whenever the access is not a selected read
    always_comb begin
        status_word = {8'd0, 8'(tx_cnt_q), 8'(rx_cnt_q),
                       2'b00, tx_ovf_q, rx_ovf_q, tx_full, tx_empty, rx_full, rx_empty};
        ctrl_word   = {29'd0, lb_mode, 1'b0, irq_en_q};
        dw.DwReadData = 32'd0;
        if (dw.DwReadEnable && sel) begin
            case (off)
                OFF_DATA:   dw.DwReadData = rx_empty ? 32'd0 : {24'd0, rx_head};
                OFF_STATUS: dw.DwReadData = status_word;
                OFF_CTRL:   dw.DwReadData = ctrl_word;
                default:    dw.DwReadData = 32'd0;
            endcase
        end
    end

    // Control state: pointers, counts, flags, CTRL and the registered interrupt
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            tx_ovf_q    <= 1'b0;
            rx_ovf_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_ovf_q    <= rx_ovf_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
        end
    end

    // FIFO storage writes; contents deliberately survive reset
    always_ff @(posedge iCLK) begin
        if (tx_push) tx_mem_q[tx_wr_ptr_q] <= dw.DwWriteData[7:0];
        if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_wdata;
    end

    assign oIRQ = irq_q;

endmodule
